// File: rtl/atcm_mul_arbiter.sv
// Round-robin arbiter feeding four requesters into one shared 8x8 multiplier,
// with a two-stage operand/result pipeline and a saturating completion counter.
module atcm_mul_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [3:0]       req_ready,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_z,
    output logic             rsp_valid,
    output logic [1:0]       rsp_id,
    output logic [15:0]      rsp_z,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int NUM_LANES = 4;

    logic [1:0]       ptr_q, ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_id_q, s1_id_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_z_q, rsp_z_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic       s2_free, s1_free;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic [1:0] idx;
    logic       accept;

    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_free = !s1_valid_q || s2_free;

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign accept = gnt_vld && s1_free && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        done_cnt_d  = done_cnt_q;

        if (s2_free) begin
            rsp_valid_d = s1_valid_q;
            rsp_id_d    = s1_id_q;
            rsp_z_d     = mul_z;
        end

        // Operands only move on a real grant so the multiplier inputs stay quiet.
        if (s1_free) begin
            s1_valid_d = gnt_vld;
            if (gnt_vld) begin
                s1_id_d = gnt_idx;
                mul_a_d = req_a[8*gnt_idx +: 8];
                mul_b_d = req_b[8*gnt_idx +: 8];
                ptr_d   = gnt_idx + 2'd1;
            end
        end

        if (rsp_valid_q && rsp_ready && (done_cnt_q != {CNT_W{1'b1}}))
            done_cnt_d = done_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            done_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_atcm_mul_arbiter.sv
// Directed bench for atcm_mul_arbiter; an exact 8x8 multiplier stands in for the shared unit.
module tb_atcm_mul_arbiter;
    logic        clk_100M = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_ready = 1'b1;

    logic [3:0]  req_ready, req_ready4;
    logic [7:0]  mul_a, mul_b, mul_a4, mul_b4;
    logic [15:0] mul_z, mul_z4;
    logic        rsp_valid, rsp_valid4;
    logic [1:0]  rsp_id, rsp_id4;
    logic [15:0] rsp_z, rsp_z4;
    logic [15:0] done_cnt;
    logic [3:0]  done_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_100M = ~clk_100M;

    assign mul_z  = {8'd0, mul_a}  * {8'd0, mul_b};
    assign mul_z4 = {8'd0, mul_a4} * {8'd0, mul_b4};

    atcm_mul_arbiter #(.CNT_W(16)) dut (
        .clk_100M(clk_100M), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
        .done_cnt(done_cnt)
    );

    atcm_mul_arbiter #(.CNT_W(4)) dut4 (
        .clk_100M(clk_100M), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready4), .mul_a(mul_a4), .mul_b(mul_b4), .mul_z(mul_z4),
        .rsp_valid(rsp_valid4), .rsp_id(rsp_id4), .rsp_z(rsp_z4), .rsp_ready(rsp_ready),
        .done_cnt(done_cnt4)
    );

    // Products for a = {4,3,2,1}, b = {6,5,4,3}: 1*3, 2*4, 3*5, 4*6.
    logic [15:0] exp_z [4] = '{16'd3, 16'd8, 16'd15, 16'd24};

    task automatic step();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_100M);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a = {8'd4, 8'd3, 8'd2, 8'd1};
        req_b = {8'd6, 8'd5, 8'd4, 8'd3};
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        #3;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin n_err++; $display("FAIL reset_mul got %0d/%0d want 0/0", mul_a, mul_b); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0 || rsp_z !== 16'd0) begin n_err++; $display("FAIL reset_rsp got id %0d z %0d want 0/0", rsp_id, rsp_z); end
        n_cmp++; if (done_cnt !== 16'd0) begin n_err++; $display("FAIL reset_done_cnt got %0d want 0", done_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        req_a = 32'd12;
        req_b = 32'd10;
        req_valid = 4'b0001;
        sample();
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready got %b want 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        sample();
        n_cmp++; if (rsp_valid !== 1'b0 || mul_a !== 8'd12 || mul_b !== 8'd10 || req_ready !== 4'b0000)
            begin n_err++; $display("FAIL single_s1 got v%b a%0d b%0d rdy%b want v0 a12 b10 rdy0000", rsp_valid, mul_a, mul_b, req_ready); end
        step();
        sample();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 16'd120)
            begin n_err++; $display("FAIL single_rsp got v%b id%0d z%0d want v1 id0 z120", rsp_valid, rsp_id, rsp_z); end
        step();
        sample();
        n_cmp++; if (done_cnt !== 16'd1 || rsp_valid !== 1'b0)
            begin n_err++; $display("FAIL single_done got cnt%0d v%b want cnt1 v0", done_cnt, rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = 4'b0000;
            sample();
            if (c < 8) begin
                n_cmp++; if (req_ready !== (4'b0001 << (c % 4)))
                    begin n_err++; $display("FAIL rr_grant c%0d got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
            end
            if (c >= 2) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_z !== exp_z[(c - 2) % 4])
                    begin n_err++; $display("FAIL rr_rsp c%0d got v%b id%0d z%0d want v1 id%0d z%0d", c, rsp_valid, rsp_id, rsp_z, (c - 2) % 4, exp_z[(c - 2) % 4]); end
            end
            step();
        end
        sample();
        n_cmp++; if (done_cnt !== 16'd8 || rsp_valid !== 1'b0)
            begin n_err++; $display("FAIL rr_done got cnt%0d v%b want cnt8 v0", done_cnt, rsp_valid); end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            sample();
            if (req_ready != 4'b0000) acc++;
            if (c >= 2) begin
                n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 16'd3)
                    begin n_err++; $display("FAIL bp_hold c%0d got rdy%b v%b id%0d z%0d want rdy0000 v1 id0 z3", c, req_ready, rsp_valid, rsp_id, rsp_z); end
            end
            step();
        end
        n_cmp++; if (acc != 2) begin n_err++; $display("FAIL bp_accepted got %0d want 2", acc); end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        sample();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_drain0 got v%b id%0d want v1 id0", rsp_valid, rsp_id); end
        step();
        sample();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_z !== 16'd8)
            begin n_err++; $display("FAIL bp_drain1 got v%b id%0d z%0d want v1 id1 z8", rsp_valid, rsp_id, rsp_z); end
        step();
        sample();
        n_cmp++; if (rsp_valid !== 1'b0 || done_cnt !== 16'd2)
            begin n_err++; $display("FAIL bp_end got v%b cnt%0d want v0 cnt2", rsp_valid, done_cnt); end
    endtask

    task automatic test_fairness();
        logic [3:0] pat [5] = '{4'b1111, 4'b1101, 4'b0111, 4'b1110, 4'b1111};
        logic [3:0] exp [5] = '{4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
        int gap, max_gap;
        gap = 0;
        max_gap = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = pat[c];
            sample();
            n_cmp++; if (req_ready !== exp[c])
                begin n_err++; $display("FAIL fair_grant c%0d got %b want %b", c, req_ready, exp[c]); end
            gap++;
            if (req_ready[2] === 1'b1) begin
                if (gap > max_gap) max_gap = gap;
                gap = 0;
            end
            step();
        end
        req_valid = 4'b0000;
        n_cmp++; if (max_gap > 4 || gap > 4) begin n_err++; $display("FAIL fair_gap got %0d want <=4", max_gap); end
        step();
        step();
        step();
    endtask

    task automatic test_reset_midop();
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        step();
        step();
        step();
        sample();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_full got v%b want 1", rsp_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_z !== 16'd0 || mul_a !== 8'd0 || req_ready !== 4'b0000 || done_cnt !== 16'd0)
            begin n_err++; $display("FAIL mid_async got v%b z%0d a%0d rdy%b cnt%0d want all 0", rsp_valid, rsp_z, mul_a, req_ready, done_cnt); end
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        sample();
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got %b want 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        sample();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale got v%b want 0", rsp_valid); end
        step();
        sample();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 16'd3)
            begin n_err++; $display("FAIL mid_rsp got v%b id%0d z%0d want v1 id0 z3", rsp_valid, rsp_id, rsp_z); end
        step();
        sample();
        n_cmp++; if (rsp_valid !== 1'b0 || done_cnt !== 16'd1)
            begin n_err++; $display("FAIL mid_end got v%b cnt%0d want v0 cnt1", rsp_valid, done_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 20; c++) step();
        req_valid = 4'b0000;
        step();
        step();
        step();
        sample();
        n_cmp++; if (done_cnt4 !== 4'd15) begin n_err++; $display("FAIL sat_cnt4 got %0d want 15", done_cnt4); end
        n_cmp++; if (done_cnt !== 16'd20) begin n_err++; $display("FAIL sat_cnt16 got %0d want 20", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_reset_midop();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
